// File: rtl/alu_pipe.sv
// Registered ALU stage with valid/ready handshake on both sides.
// Single-cycle ops complete in one clock. MULLO/MULHI run an iterative
// shift-add multiply that retires one bit of b per cycle.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned CntW = SHW + 1;
  localparam int unsigned ProdW = 2 * WIDTH;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;

  localparam logic [4:0] OpAdd   = 5'h00;
  localparam logic [4:0] OpSubAb = 5'h01;
  localparam logic [4:0] OpSubBa = 5'h02;
  localparam logic [4:0] OpAnd   = 5'h03;
  localparam logic [4:0] OpOr    = 5'h04;
  localparam logic [4:0] OpXor   = 5'h05;
  localparam logic [4:0] OpSll   = 5'h06;
  localparam logic [4:0] OpSrl   = 5'h07;
  localparam logic [4:0] OpSra   = 5'h08;
  localparam logic [4:0] OpNotB  = 5'h09;
  localparam logic [4:0] OpPassB = 5'h0A;
  localparam logic [4:0] OpHiLd  = 5'h0B;
  localparam logic [4:0] OpLtu   = 5'h0C;
  localparam logic [4:0] OpLeu   = 5'h0D;
  localparam logic [4:0] OpEq    = 5'h0E;
  localparam logic [4:0] OpOne   = 5'h0F;
  localparam logic [4:0] OpLts   = 5'h10;
  localparam logic [4:0] OpLes   = 5'h11;
  localparam logic [4:0] OpMulLo = 5'h12;
  localparam logic [4:0] OpMulHi = 5'h13;

  // Control and multiplier state
  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ProdW-1:0] acc_q, acc_d;
  logic [ProdW-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             hi_q, hi_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  // Single-cycle datapath
  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] sub_ab, sub_ba, sra_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_illegal, is_mul;

  // Multiply step
  logic [ProdW-1:0] mul_sum;
  logic [WIDTH-1:0] mul_res;

  logic accept;

  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ab  = a - b;
  assign sub_ba  = b - a;
  assign shamt   = b[SHW-1:0];
  assign sra_res = $signed(a) >>> shamt;

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res = hi_q ? mul_sum[ProdW-1:WIDTH] : mul_sum[WIDTH-1:0];

  // Decode the opcode into a single-cycle result, carry and illegal flag
  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    is_mul      = 1'b0;
    case (op)
      OpAdd: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
      end
      OpSubAb: begin
        alu_res   = sub_ab;
        alu_carry = (a < b);
      end
      OpSubBa: begin
        alu_res   = sub_ba;
        alu_carry = (b < a);
      end
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpSll:   alu_res = a << shamt;
      OpSrl:   alu_res = a >> shamt;
      OpSra:   alu_res = sra_res;
      OpNotB:  alu_res = ~b;
      OpPassB: alu_res = b;
      OpHiLd:  alu_res = a | (b << (WIDTH / 2));
      OpLtu:   alu_res = WIDTH'(a < b);
      OpLeu:   alu_res = WIDTH'(a <= b);
      OpEq:    alu_res = WIDTH'(a == b);
      OpOne:   alu_res = WIDTH'(1);
      OpLts:   alu_res = WIDTH'($signed(a) < $signed(b));
      OpLes:   alu_res = WIDTH'($signed(a) <= $signed(b));
      OpMulLo, OpMulHi: is_mul = 1'b1;
      default: alu_illegal = 1'b1;
    endcase
  end

  // Next-state: handshake, output register load, multiply sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    hi_d        = hi_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;

    // Retire the current result; a load below may re-assert valid
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = StMul;
            cnt_d    = CntW'(WIDTH);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            hi_d     = op[0];
          end else begin
            res_d       = alu_res;
            carry_d     = alu_carry;
            illegal_d   = alu_illegal;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        // Last bit folded in this cycle: publish the product
        if (cnt_q == CntW'(1)) begin
          state_d     = StIdle;
          res_d       = mul_res;
          carry_d     = 1'b0;
          illegal_d   = 1'b0;
          zero_d      = (mul_res == '0);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      hi_q        <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=32.
module tb_alu_pipe;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         carry, zero, illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .carry    (carry),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single accept edge; in_ready must already be high
  task automatic issue(input logic [4:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    op       = o;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    check("issue_ready", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    a        = '1;
    b        = '1;
  endtask

  // Single-cycle op followed by a check of all result fields
  task automatic alu1(input string tag, input logic [4:0] o, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic [W-1:0] er, input logic ec,
                      input logic eil);
    issue(o, va, vb);
    check({tag, "_v"}, {63'b0, out_valid}, 64'd1);
    check({tag, "_res"}, {32'b0, res}, {32'b0, er});
    check({tag, "_cz"}, {62'b0, carry, zero}, {62'b0, ec, (er == '0)});
    check({tag, "_ill"}, {63'b0, illegal}, {63'b0, eil});
  endtask

  // Multiply: in_ready low for W cycles, result on edge accept+W
  task automatic mul(input string tag, input logic [4:0] o, input logic [W-1:0] va,
                     input logic [W-1:0] vb, input logic [W-1:0] er);
    int bad = 0;
    issue(o, va, vb);
    for (int i = 1; i < W; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      tick();
    end
    if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    check({tag, "_busy"}, 64'(bad), 64'd0);
    tick();
    check({tag, "_v"}, {63'b0, out_valid}, 64'd1);
    check({tag, "_res"}, {32'b0, res}, {32'b0, er});
    check({tag, "_flags"}, {61'b0, carry, zero, illegal}, 64'd0);
    check({tag, "_rdy"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    int bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("rst_out", {59'b0, out_valid, carry, zero, illegal, in_ready}, 64'd1);
    check("rst_res", {32'b0, res}, 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_v", {63'b0, out_valid}, 64'd0);

    // Zero-bubble streaming of add then sub
    op = 5'h00; a = 32'hFFFF_FFFF; b = 32'h1; in_valid = 1'b1;
    tick();
    check("st0_v", {63'b0, out_valid}, 64'd1);
    check("st0_res", {32'b0, res}, 64'd0);
    check("st0_cz", {62'b0, carry, zero}, 64'd3);
    op = 5'h01; a = 32'h0; b = 32'h1;
    check("st1_rdy", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("st1_v", {63'b0, out_valid}, 64'd1);
    check("st1_res", {32'b0, res}, 64'h0000_0000_FFFF_FFFF);
    check("st1_cz", {62'b0, carry, zero}, 64'd2);

    alu1("sra",  5'h08, 32'h8000_0000, 32'h24,   32'hF800_0000, 1'b0, 1'b0);
    alu1("srl",  5'h07, 32'h8000_0000, 32'h24,   32'h0800_0000, 1'b0, 1'b0);
    alu1("lts",  5'h10, 32'hFFFF_FFFF, 32'h1,    32'h1,         1'b0, 1'b0);
    alu1("ltu",  5'h0C, 32'hFFFF_FFFF, 32'h1,    32'h0,         1'b0, 1'b0);
    alu1("les",  5'h11, 32'h5,         32'h5,    32'h1,         1'b0, 1'b0);
    alu1("subba",5'h02, 32'h1,         32'h0,    32'hFFFF_FFFF, 1'b1, 1'b0);
    alu1("hild", 5'h0B, 32'h1234,      32'hABCD, 32'hABCD_1234, 1'b0, 1'b0);
    alu1("sll",  5'h06, 32'h3,         32'h41,   32'h6,         1'b0, 1'b0);
    alu1("and",  5'h03, 32'hF0F0_FFFF, 32'h0FF0_0001, 32'h00F0_0001, 1'b0, 1'b0);
    alu1("notb", 5'h09, 32'h0,         32'h0F0F_0000, 32'hF0F0_FFFF, 1'b0, 1'b0);
    alu1("ill",  5'h15, 32'h7,         32'h9,    32'h0,         1'b0, 1'b1);

    mul("mulhi", 5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    mul("mullo", 5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    mul("mul2",  5'h12, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500);

    // Reset mid-multiply aborts it
    tick();
    issue(5'h13, 32'h1234_5678, 32'h9ABC_DEF0);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_st", {62'b0, out_valid, in_ready}, 64'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    check("abort_nores", 64'(bad), 64'd0);

    // Back-pressure holds the result and blocks issue
    out_ready = 1'b0;
    alu1("bp", 5'h00, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0);
    op = 5'h00; a = 32'h1; b = 32'h1; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || res !== 32'h7) bad++;
      tick();
    end
    check("bp_hold", 64'(bad), 64'd0);
    check("bp_res", {32'b0, res}, 64'd7);
    op = 5'h1F; a = 32'h55; b = 32'hAA;
    out_ready = 1'b1;
    #1;
    check("bp_rdy", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_new", {32'b0, res}, 64'd0);
    check("bp_flags", {60'b0, out_valid, carry, zero, illegal}, 64'hB);
    tick();
    check("drain", {63'b0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational CPU ALU.
- Adds:
  - generic datapath width;
  - a valid/ready handshake on input and output;
  - a true arithmetic shift right;
  - signed compares;
  - an iterative multi-cycle multiplier (low and high product).
- Sits between the decode/operand-fetch stage and writeback.
- Back-pressure from writeback stalls issue.

Parameters:
- WIDTH, 32, datapath width in bits. Power of two, minimum 8.
- SHW, $clog2(WIDTH), number of low b bits used as the shift amount. Derived; do not override.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  operation presented on op/a/b
- in_ready  out  1  block can accept an operation this cycle
- op  in  5  opcode
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  res/carry/zero/illegal are valid
- out_ready  in  1  consumer takes the result this cycle
- res  out  WIDTH  result
- carry  out  1  carry/borrow for add/sub, otherwise 0
- zero  out  1  res == 0
- illegal  out  1  opcode was unassigned

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, res=0, carry=0, zero=0, illegal=0;
  - state=IDLE, iteration counter=0, multiplier accumulator=0;
  - overrides everything, including a multiply in progress (it is aborted and no result is produced).
- States:
  - IDLE: accepts work.
  - MUL: iterative multiply running.
- Readiness and acceptance:
  - in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational, no dependence on in_valid.
  - Accept = in_valid && in_ready. op/a/b are sampled only on accept; they may change freely otherwise.
- Output register:
  - When out_valid=1 and out_ready=0, res/carry/zero/illegal and out_valid hold stable.
  - out_valid drops on an out_ready edge, unless a new result loads at the same edge.
- Single-cycle ops (latency 1, throughput 1/cycle):
  - 0x00 a+b; carry = bit WIDTH of zero-extended sum.
  - 0x01 a-b; carry = 1 on borrow (a<b unsigned).
  - 0x02 b-a; carry = 1 on borrow (b<a unsigned).
  - 0x03 a&b.
  - 0x04 a|b.
  - 0x05 a^b.
  - 0x06 a<<b[SHW-1:0].
  - 0x07 logical a>>b[SHW-1:0].
  - 0x08 arithmetic a>>>b[SHW-1:0], sign-filled.
  - 0x09 ~b.
  - 0x0A b.
  - 0x0B a | (b<<(WIDTH/2)), truncated to WIDTH.
  - 0x0C unsigned a<b.
  - 0x0D unsigned a<=b.
  - 0x0E a==b.
  - 0x0F constant 1.
  - 0x10 signed a<b.
  - 0x11 signed a<=b.
  - Compare results are 0/1, zero-extended to WIDTH.
  - Shift amount bits above SHW are ignored.
- Multiply ops (unsigned shift-add, one bit of b per cycle):
  - 0x12 MULLO: res = low WIDTH bits of a*b.
  - 0x13 MULHI: res = high WIDTH bits of a*b.
  - On accept: state→MUL, 2*WIDTH-bit accumulator cleared, counter=WIDTH.
  - Each MUL cycle: if current b bit set, add a (shifted) into the accumulator; decrement the counter.
  - When the counter reaches 0: load res, out_valid=1, state→IDLE.
  - Timing: accepted at edge t → out_valid rises at edge t+WIDTH.
  - in_ready=0 throughout MUL.
  - A previous result still awaiting out_ready is not overwritten. Multiply is only accepted when in_ready, so the output register is free or being drained at the accept edge.
- Unassigned opcodes 0x14–0x1F: res=0, illegal=1, latency 1. illegal=0 for all assigned ops.
- carry=0 for every op other than 0x00–0x02.
- zero is computed from the loaded res value, for all ops.
- Simultaneous out_ready and accept in IDLE: the old result retires and the new result loads at the same edge. out_valid stays 1, giving zero-bubble streaming.

Test Plan:
- Reset then idle → out_valid=0, res=0, in_ready=1. Assert rst_n=0 for one edge during MUL → state IDLE, out_valid=0, in_ready=1 next cycle.
- WIDTH=32, out_ready=1, stream 0x00 a=0xFFFFFFFF b=1 then 0x01 a=0 b=1 on consecutive cycles → res 0x0 carry=1 zero=1, then res 0xFFFFFFFF carry=1 zero=0, on consecutive cycles with out_valid held high.
- op 0x08 a=0x80000000 b=0x24 → res 0xF8000000 (shift by 4; b[31:5] ignored). op 0x07 same operands → 0x08000000.
- op 0x10 a=0xFFFFFFFF b=1 → res 1. op 0x0C same operands → res 0.
- op 0x13 a=0xFFFFFFFF b=0xFFFFFFFF → in_ready low for 32 cycles, out_valid at accept+32, res=0xFFFFFFFE. op 0x12 with the same operands → res=0x00000001.
- out_ready=0 with a result pending → in_ready=0 and res stable for 10 cycles. Then raise out_ready with a 0x1F op presented → the old result retires, next cycle res=0 and illegal=1.
